mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Backing-memory responder on the receive side of the cache's memory bus. Consumes the cache's req_op/req_addr/req_data every cycle and answers reads with rsp_vld/rsp_data after a fixed latency.
- Fully pipelined: no back-pressure, one request accepted per cycle, and up to LATENCY reads can be in flight.
- Serves as the main-memory model in simulation and as the synthesizable memory stage beneath the cache.

Parameters:
- ADDR_WIDTH, 6, request address width in bits; memory depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width in bits.
- LATENCY, 3, cycles from read acceptance to rsp_vld; legal range 1..16.

Ports:
- clk  input  1  bus clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_op  input  2  request op: 0 NOP, 1 READ, 2 WRITE, 3 reserved (treated as NOP).
- req_addr  input  ADDR_WIDTH  word address of the request.
- req_data  input  DATA_WIDTH  write data; ignored unless op is WRITE.
- rsp_vld  output  1  one-cycle pulse marking a read response.
- rsp_data  output  DATA_WIDTH  read data, valid when rsp_vld=1.
- rd_count  output  16  number of READs accepted since reset; wraps at 65535 to 0.
- wr_count  output  16  number of WRITEs accepted since reset; wraps at 65535 to 0.

Behaviour:
- Reset:
  - Asynchronous assertion; release is sampled on the next clk edge.
  - While rst_n=0: rsp_vld=0, rsp_data=0, rd_count=0, wr_count=0.
  - All in-flight reads are discarded; all memory words are cleared to 0.
- Acceptance:
  - req_op is sampled on every posedge with rst_n=1. There is no ready signal; every request is accepted.
  - NOP and reserved: no state change except the pipeline advancing.
- WRITE at edge N:
  - mem[req_addr] <= req_data at edge N.
  - wr_count increments at edge N.
  - No response is generated.
- READ at edge N:
  - Data is mem[req_addr] as it stood before edge N. A WRITE at edge N-1 to the same address is visible.
  - The data travels down a LATENCY-stage valid/data shift pipeline.
  - rsp_vld=1 and rsp_data=that word in the cycle following edge N+LATENCY-1. For LATENCY=1, outputs are registered at edge N.
  - rd_count increments at edge N.
- Ordering:
  - Responses return strictly in request order, with no gaps and no merging.
  - Back-to-back READs on consecutive edges give rsp_vld high on consecutive cycles.
  - A WRITE accepted after a READ does not alter that READ's in-flight data, even to the same address.
- rsp_data:
  - Holds its last value while rsp_vld=0.
  - Is 0 only after reset, until the first response.
- Address handling: the full address is used; there is no aliasing or bounds error.
- Counter wrap: 16-bit modulo arithmetic; no saturation or flag.
- Reset mid-operation:
  - Pending responses never appear, even if the pipeline was full.
  - The first cycle after release behaves as an empty pipeline.
- Parameter check: a LATENCY outside 1..16 triggers a $fatal at elaboration.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then NOP for 10 cycles -> rsp_vld stays 0; rsp_data, rd_count and wr_count all 0.
- Write then read, LATENCY=3:
  - WRITE addr 0x05 data 0xA5 at edge 1, READ 0x05 at edge 2.
  - Required: rsp_vld=1 with rsp_data=0xA5 only in the cycle after edge 4; wr_count=1, rd_count=1.
- Pipelined reads:
  - Preload 0x00..0x03 with 0x10..0x13, then READ 0,1,2,3 on consecutive edges.
  - Required: four consecutive rsp_vld cycles carrying 0x10,0x11,0x12,0x13 in order.
- Read/write hazard:
  - mem[0x07]=0x11; READ 0x07 at edge N, WRITE 0x07=0x22 at edge N+1, READ 0x07 at edge N+2.
  - Required: responses 0x11 then 0x22.
- Reset mid-flight: issue 3 READs, assert rst_n low after the second accept edge -> no rsp_vld ever appears for them; counters read 0 after release.
- Reserved op and counter wrap:
  - op=3 with addr 0x01 data 0xFF -> mem[0x01] unchanged, no response, counters unchanged.
  - 65536 WRITEs -> wr_count returns to 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl: backing-memory responder beneath the cache's memory bus.
// Accepts one request per cycle with no back-pressure. WRITEs update the word
// array immediately. READs capture the pre-edge word and carry it down a
// LATENCY-stage valid/data shift pipeline, so responses come back in order
// after a fixed latency.
//
// Ports:
//   clk       bus clock, all state updates on posedge
//   rst_n     asynchronous active-low reset (clears memory, pipeline, counters)
//   req_op    0 NOP, 1 READ, 2 WRITE, 3 reserved (behaves as NOP)
//   req_addr  word address of the request
//   req_data  write data, used only by WRITE
//   rsp_vld   one-cycle pulse per read response
//   rsp_data  read data; holds its last value while rsp_vld is low
//   rd_count  READs accepted since reset, 16-bit wrapping
//   wr_count  WRITEs accepted since reset, 16-bit wrapping
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 16;
    localparam logic [1:0]  OP_READ  = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd2;

    // Elaboration-time guard on the pipeline depth.
    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $fatal(1, "mem_ctrl: LATENCY must be in 1..16");
    end

    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d  [DEPTH];
    logic                  vld_q  [LATENCY];
    logic                  vld_d  [LATENCY];
    logic [DATA_WIDTH-1:0] data_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_d [LATENCY];
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;
    logic                  is_rd_c;
    logic                  is_wr_c;

    // Next-state: memory write, read pipeline shift, request counters.
    always_comb begin
        is_rd_c    = (req_op == OP_READ);
        is_wr_c    = (req_op == OP_WRITE);
        mem_d      = mem_q;
        vld_d      = vld_q;
        data_d     = data_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;

        if (is_wr_c) begin
            mem_d[req_addr] = req_data;
            wr_count_d      = wr_count_q + CNT_W'(1);
        end

        // Stage 0 samples the array before this edge's write lands, so a
        // WRITE issued later never disturbs a READ already in flight.
        vld_d[0] = is_rd_c;
        if (is_rd_c) begin
            data_d[0]  = mem_q[req_addr];
            rd_count_d = rd_count_q + CNT_W'(1);
        end

        // Data stages only load behind a valid, so the last stage (rsp_data)
        // holds the most recent response through idle cycles.
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // State registers; reset discards in-flight reads and clears the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < int'(LATENCY); i++) begin
                vld_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            mem_q      <= mem_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rsp_vld  = vld_q[LATENCY-1];
    assign rsp_data = data_q[LATENCY-1];
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule
